// File: rtl/filtro_iir_cascada_param.sv
// Cascade of S direct-form-I biquads sharing one signed MAC, with run-time
// programmable coefficients and saturating section outputs.
module filtro_iir_cascada_param #(
  parameter int unsigned N = 25,
  parameter int unsigned F = 14,
  parameter int unsigned S = 2,
  parameter int unsigned G = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Bandera_ADC,
  input  logic [N-1:0]             Uk,
  input  logic                     Coef_We,
  input  logic [$clog2(5*S)-1:0]   Coef_Addr,
  input  logic [N-1:0]             Coef_Dato,
  output logic [N-1:0]             Yk,
  output logic                     Bandera_Listo,
  output logic                     Ocupado,
  output logic                     Saturado,
  output logic                     Sobrecarga
);

  localparam int unsigned AW   = $clog2(5*S);
  localparam int unsigned SW   = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned NC   = 5*S;
  localparam int unsigned PW   = 2*N;
  localparam int unsigned ACCW = 2*N + G;

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  state_t state, state_nx;

  logic [SW-1:0]           sec;
  logic [2:0]              tap;
  logic signed [N-1:0]     coef [NC];
  logic signed [N-1:0]     x1 [S];
  logic signed [N-1:0]     x2 [S];
  logic signed [N-1:0]     y1 [S];
  logic signed [N-1:0]     y2 [S];
  logic signed [N-1:0]     x_in;
  logic signed [ACCW-1:0]  acc;
  logic                    sticky;

  logic [AW-1:0]           coef_idx_c;
  logic signed [N-1:0]     coef_sel_c;
  logic signed [N-1:0]     op_sel_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [ACCW-1:0]  prod_ext_c;
  logic signed [ACCW-1:0]  acc_nx_c;
  logic signed [ACCW-1:0]  shifted_c;
  logic                    clip_c;
  logic signed [N-1:0]     y_sat_c;
  logic                    coef_wr_c;
  logic                    last_sec_c;

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (Bandera_ADC) state_nx = MAC;
      MAC:  if (tap == 3'd4) state_nx = WB;
      WB:   state_nx = last_sec_c ? DONE : MAC;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // MAC operand selection: taps 0..2 feed-forward, 3..4 feedback (subtracted)
  always_comb begin
    coef_idx_c = AW'(32'd5 * 32'(sec) + 32'(tap));
    coef_sel_c = coef[coef_idx_c];
    case (tap)
      3'd0:    op_sel_c = x_in;
      3'd1:    op_sel_c = x1[sec];
      3'd2:    op_sel_c = x2[sec];
      3'd3:    op_sel_c = y1[sec];
      default: op_sel_c = y2[sec];
    endcase
    prod_c     = PW'(coef_sel_c) * PW'(op_sel_c);
    prod_ext_c = ACCW'(prod_c);
    acc_nx_c   = (tap >= 3'd3) ? acc - prod_ext_c : acc + prod_ext_c;
  end

  // Floor-scale and clip to the N-bit signed range
  always_comb begin
    shifted_c = acc >>> F;
    clip_c    = !((&shifted_c[ACCW-1:N-1]) || !(|shifted_c[ACCW-1:N-1]));
    y_sat_c   = clip_c ? {shifted_c[ACCW-1], {(N-1){~shifted_c[ACCW-1]}}}
                       : shifted_c[N-1:0];
  end

  assign last_sec_c = (sec == SW'(S-1));
  assign coef_wr_c  = Coef_We && (state == IDLE) && !Bandera_ADC && (32'(Coef_Addr) < NC);

  // Datapath, history and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NC; i++) coef[i] <= (i % 5 == 0) ? N'(1 << F) : '0;
      for (int i = 0; i < S; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
      sec           <= '0;
      tap           <= '0;
      x_in          <= '0;
      acc           <= '0;
      sticky        <= 1'b0;
      Yk            <= '0;
      Bandera_Listo <= 1'b0;
      Ocupado       <= 1'b0;
      Saturado      <= 1'b0;
      Sobrecarga    <= 1'b0;
    end else begin
      Bandera_Listo <= 1'b0;
      Saturado      <= 1'b0;
      Sobrecarga    <= Bandera_ADC && (state != IDLE);
      Ocupado       <= (state_nx != IDLE);
      if (coef_wr_c) coef[Coef_Addr] <= Coef_Dato;
      case (state)
        IDLE: begin
          if (Bandera_ADC) begin
            x_in   <= Uk;
            sticky <= 1'b0;
            sec    <= '0;
            tap    <= '0;
            acc    <= '0;
          end
        end
        MAC: begin
          acc <= acc_nx_c;
          tap <= tap + 3'd1;
        end
        WB: begin
          x2[sec] <= x1[sec];
          x1[sec] <= x_in;
          y2[sec] <= y1[sec];
          y1[sec] <= y_sat_c;
          x_in    <= y_sat_c;
          sticky  <= sticky | clip_c;
          if (!last_sec_c) begin
            sec <= sec + SW'(1);
            tap <= '0;
            acc <= '0;
          end
        end
        DONE: begin
          Yk            <= x_in;
          Bandera_Listo <= 1'b1;
          Saturado      <= sticky;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_iir_cascada_param.sv
// Scoreboard bench for filtro_iir_cascada_param (S=2; section 1 left at
// identity so section-0 programming is observed directly on Yk).
module tb_filtro_iir_cascada_param;

  localparam int unsigned N   = 25;
  localparam int unsigned F   = 14;
  localparam int unsigned S   = 2;
  localparam int unsigned G   = 4;
  localparam int unsigned AW  = $clog2(5*S);
  localparam int          LAT = 6*S + 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Bandera_ADC = 1'b0;
  logic [N-1:0]  Uk = '0;
  logic          Coef_We = 1'b0;
  logic [AW-1:0] Coef_Addr = '0;
  logic [N-1:0]  Coef_Dato = '0;
  logic [N-1:0]  Yk;
  logic          Bandera_Listo, Ocupado, Saturado, Sobrecarga;

  filtro_iir_cascada_param #(.N(N), .F(F), .S(S), .G(G)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Bandera_ADC(Bandera_ADC), .Uk(Uk),
    .Coef_We(Coef_We), .Coef_Addr(Coef_Addr), .Coef_Dato(Coef_Dato),
    .Yk(Yk), .Bandera_Listo(Bandera_Listo), .Ocupado(Ocupado),
    .Saturado(Saturado), .Sobrecarga(Sobrecarga)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int y;
    bit sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int listo_cnt = 0;
  int sob_cnt = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever the DUT strobes a result
  always @(negedge Clk) begin
    if (Sobrecarga) sob_cnt++;
    if (Bandera_Listo) begin
      exp_t e;
      listo_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_listo: got Yk=%0d, expected no strobe", $signed(Yk));
      end else begin
        e = sb.pop_front();
        check("yk", int'($signed(Yk)), e.y);
        check("saturado", int'(Saturado), int'(e.sat));
        check("latency", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    Bandera_ADC = 1'b0;
    Coef_We = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge Clk);
    Coef_We = 1'b1;
    Coef_Addr = AW'(addr);
    Coef_Dato = N'(val);
    @(negedge Clk);
    Coef_We = 1'b0;
  endtask

  // Issue a sample; the edge that samples it is cyc+1
  task automatic send(input int u, input int exp_y, input bit exp_sat, input bit expect_out);
    exp_t e;
    @(negedge Clk);
    Uk = N'(u);
    Bandera_ADC = 1'b1;
    if (expect_out) begin
      e.y = exp_y;
      e.sat = exp_sat;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge Clk);
    Bandera_ADC = 1'b0;
  endtask

  task automatic run_sample(input int u, input int exp_y, input bit exp_sat);
    send(u, exp_y, exp_sat, 1'b1);
    repeat (LAT + 2) @(negedge Clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  int t2_y[4] = '{1000, 500, 250, 125};
  int t2_x[4] = '{1000, 0, 0, 0};

  initial begin
    int base;
    // Reset defaults
    #2;
    check("rst_yk", int'(Yk), 0);
    check("rst_listo", int'(Bandera_Listo), 0);
    check("rst_ocupado", int'(Ocupado), 0);
    check("rst_saturado", int'(Saturado), 0);
    check("rst_sobrecarga", int'(Sobrecarga), 0);
    do_reset();

    // T1 identity coefficients
    send(1000, 1000, 1'b0, 1'b1);
    repeat (3) @(negedge Clk);
    check("ocupado_mid", int'(Ocupado), 1);
    repeat (LAT) @(negedge Clk);
    run_sample(-5, -5, 1'b0);
    drain("t1_drain");

    // T2 single-pole feedback
    do_reset();
    write_coef(0, 16384);
    write_coef(3, -8192);
    for (int i = 0; i < 4; i++) run_sample(t2_x[i], t2_y[i], 1'b0);
    drain("t2_drain");

    // T3 two-tap FIR with floor rounding
    do_reset();
    write_coef(0, 8192);
    write_coef(1, 8192);
    run_sample(3, 1, 1'b0);
    run_sample(0, 1, 1'b0);
    run_sample(0, 0, 1'b0);
    run_sample(-3, -2, 1'b0);
    run_sample(0, -2, 1'b0);
    drain("t3_drain");

    // T4 saturation both rails, then sticky flag cleared
    do_reset();
    write_coef(0, 32768);
    run_sample(10000000, 16777215, 1'b1);
    run_sample(-10000000, -16777216, 1'b1);
    run_sample(100, 200, 1'b0);
    drain("t4_drain");

    // T5 overrun strobe plus guarded coefficient write
    do_reset();
    base = listo_cnt;
    sob_cnt = 0;
    send(7, 7, 1'b0, 1'b1);
    @(negedge Clk);
    Uk = N'(99);
    Bandera_ADC = 1'b1;
    Coef_We = 1'b1;
    Coef_Addr = '0;
    Coef_Dato = '0;
    @(negedge Clk);
    Bandera_ADC = 1'b0;
    Coef_We = 1'b0;
    repeat (LAT + 4) @(negedge Clk);
    check("t5_sobrecarga", sob_cnt, 1);
    check("t5_one_listo", listo_cnt - base, 1);
    run_sample(11, 11, 1'b0);
    drain("t5_drain");

    // T6 reset mid-run restores identity and suppresses the result
    write_coef(0, 32768);
    base = listo_cnt;
    send(50, 0, 1'b0, 1'b0);
    repeat (4) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("t6_yk_rst", int'(Yk), 0);
    check("t6_ocupado_rst", int'(Ocupado), 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (LAT + 2) @(negedge Clk);
    check("t6_no_listo", listo_cnt - base, 0);
    check("t6_yk_hold", int'(Yk), 0);
    run_sample(21, 21, 1'b0);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
